// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding, iteration default and counter width helper for the divider controller
package div_ctrl_pkg;
  localparam int ITER_DEF = 8;
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_LOAD_A = 4'd1;
  localparam state_t S_LOAD_Q = 4'd2;
  localparam state_t S_LOAD_M = 4'd3;
  localparam state_t S_CHECK  = 4'd4;
  localparam state_t S_SHIFT  = 4'd5;
  localparam state_t S_EVAL   = 4'd6;
  localparam state_t S_OUT_Q  = 4'd7;
  localparam state_t S_OUT_A  = 4'd8;
  localparam state_t S_DONE   = 4'd9;
  localparam state_t S_ERR    = 4'd10;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: request, datapath status and control-word bundle between datapath (master) and controller (slave)
interface div_ctrl_if;
  logic start;
  logic diff_neg;
  logic m_zero;
  logic c0;
  logic c1;
  logic c2;
  logic c3;
  logic c4;
  logic c5;
  logic c6;
  logic c7;
  logic c8;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, diff_neg, m_zero,
    input  c0, c1, c2, c3, c4, c5, c6, c7, c8, busy, done, err
  );
  modport slave (
    input  start, diff_neg, m_zero,
    output c0, c1, c2, c3, c4, c5, c6, c7, c8, busy, done, err
  );
endinterface

// File: rtl/div_iter_cnt.sv
// div_iter_cnt: shift/subtract pass counter that holds at ITER-1 and flags the final pass
module div_iter_cnt
  import div_ctrl_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int W = cnt_w(ITER);
  localparam logic [W-1:0] LAST = W'(ITER - 1);
  logic [W-1:0] cnt;
  // count EVAL passes; stopping at the final value keeps the counter from wrapping
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !last) cnt <= cnt + W'(1);
  assign last = cnt == LAST;
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: restoring-division sequencer driving the A/Q/M datapath control word
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input logic     clk,
  input logic     rst_b,
  div_ctrl_if.slave bus
);
  state_t state;
  state_t nxt;
  logic   last;
  div_iter_cnt #(.ITER(ITER)) u_cnt (
    .clk  (clk),
    .rst_b(rst_b),
    .clr  (state == S_CHECK),
    .inc  (state == S_EVAL),
    .last (last)
  );
  // state register; reset abandons any division in flight
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= S_IDLE;
    else state <= nxt;
  // sequencing: fixed load/output steps around a SHIFT/EVAL loop of ITER passes
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:   nxt = bus.start ? S_LOAD_A : S_IDLE;
      S_LOAD_A: nxt = S_LOAD_Q;
      S_LOAD_Q: nxt = S_LOAD_M;
      S_LOAD_M: nxt = S_CHECK;
      S_CHECK:  nxt = bus.m_zero ? S_ERR : S_SHIFT;
      S_SHIFT:  nxt = S_EVAL;
      S_EVAL:   nxt = last ? S_OUT_Q : S_SHIFT;
      S_OUT_Q:  nxt = S_OUT_A;
      S_OUT_A:  nxt = S_DONE;
      default:  nxt = S_IDLE;
    endcase
  end
  // control word decoded from state; only the A write-back and Q[0] set look at the adder sign
  assign bus.c0   = state == S_LOAD_A;
  assign bus.c1   = state == S_LOAD_Q;
  assign bus.c2   = state == S_LOAD_M;
  assign bus.c3   = state == S_EVAL && !bus.diff_neg;
  assign bus.c4   = state == S_EVAL;
  assign bus.c5   = state == S_EVAL && !bus.diff_neg;
  assign bus.c6   = state == S_SHIFT;
  assign bus.c7   = state == S_OUT_Q;
  assign bus.c8   = state == S_OUT_A;
  assign bus.busy = state != S_IDLE;
  assign bus.done = state == S_DONE;
  assign bus.err  = state == S_ERR;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: random and directed divisions through a behavioural A/Q/M datapath, scored against arithmetic results and timing
module tb_div_ctrl;
  localparam int ITER = 8;
  typedef struct {
    bit is_err;
    int at;
    int q;
    int r;
  } exp_t;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int edge_n = 0;
  int free_edge = 0;
  int busy_lo = 0;
  int busy_hi = -1;
  int op_hi = 0;
  int op_lo = 0;
  int op_dv = 1;
  bit fin = 1'b0;
  bit fin_done = 1'b0;
  logic [15:0] a_r = '0;
  logic [7:0] q_r = '0;
  logic [7:0] m_r = 8'd1;
  logic [7:0] q_out = '0;
  logic [15:0] r_out = '0;
  int n6 = 0;
  int n5 = 0;
  int n3 = 0;
  div_ctrl_if bus();
  div_ctrl #(.ITER(ITER)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  assign bus.diff_neg = a_r < {8'd0, m_r};
  assign bus.m_zero = m_r == 8'd0;
  // datapath: registers follow the control word, outbus captures at c7/c8
  always @(posedge clk) begin
    if (bus.c0) begin
      a_r <= 16'(op_hi);
      n6 <= 0;
      n5 <= 0;
      n3 <= 0;
    end
    if (bus.c1) q_r <= 8'(op_lo);
    if (bus.c2) m_r <= 8'(op_dv);
    if (bus.c6) begin
      a_r <= {a_r[14:0], q_r[7]};
      q_r <= {q_r[6:0], 1'b0};
      n6 <= n6 + 1;
    end
    if (bus.c3) begin
      a_r <= a_r - {8'd0, m_r};
      n3 <= n3 + 1;
    end
    if (bus.c5) begin
      q_r[0] <= 1'b1;
      n5 <= n5 + 1;
    end
    if (bus.c7) q_out <= q_r;
    if (bus.c8) r_out <= a_r;
  end
  // reference: an accepted start yields quotient/remainder by arithmetic, done 23 edges later or err 5 later
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst_b) begin
      sb.delete();
      free_edge <= edge_n + 1;
      busy_lo <= 0;
      busy_hi <= -1;
    end else if (bus.start && edge_n + 1 >= free_edge) begin
      busy_lo <= edge_n + 1;
      if (op_dv == 0) begin
        sb.push_back('{1'b1, edge_n + 5, 0, 0});
        free_edge <= edge_n + 7;
        busy_hi <= edge_n + 5;
      end else begin
        sb.push_back('{1'b0, edge_n + 23, (op_hi * 256 + op_lo) / op_dv, (op_hi * 256 + op_lo) % op_dv});
        free_edge <= edge_n + 25;
        busy_hi <= edge_n + 23;
      end
    end
  end
  // monitor: invariants every cycle, pop and compare on done/err
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_b) begin
      checks++;
      if ({bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6, bus.c7, bus.c8, bus.busy, bus.done, bus.err} !== 12'd0) begin
        errors++;
        $display("FAIL reset_outputs edge=%0d got c0..c8,busy,done,err=%b want all zero", edge_n,
                 {bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6, bus.c7, bus.c8, bus.busy, bus.done, bus.err});
      end
    end else begin
      checks += 2;
      if ($countones({bus.c0, bus.c1, bus.c2, bus.c3, bus.c6, bus.c7, bus.c8}) > 1) begin
        errors++;
        $display("FAIL onehot edge=%0d got c0,c1,c2,c3,c6,c7,c8=%b want at most one high", edge_n,
                 {bus.c0, bus.c1, bus.c2, bus.c3, bus.c6, bus.c7, bus.c8});
      end
      if (bus.busy !== (edge_n >= busy_lo && edge_n <= busy_hi)) begin
        errors++;
        $display("FAIL busy edge=%0d got=%b want=%b", edge_n, bus.busy, edge_n >= busy_lo && edge_n <= busy_hi);
      end
      if (sb.size() != 0 && sb[0].at < edge_n) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_result edge=%0d got nothing want %s at edge %0d", edge_n, e.is_err ? "err" : "done", e.at);
      end
      if (bus.done || bus.err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse edge=%0d got done=%b err=%b want no pulse", edge_n, bus.done, bus.err);
        end else begin
          e = sb.pop_front();
          if (bus.err !== e.is_err || bus.done !== !e.is_err || e.at != edge_n ||
              (!e.is_err && (int'(q_out) != e.q || int'(r_out) != e.r || n6 != ITER || n5 != $countones(e.q))) ||
              (e.is_err && (n6 != 0 || n3 != 0))) begin
            errors++;
            $display("FAIL result edge=%0d got done=%b err=%b q=%0d r=%0d c6s=%0d c5s=%0d c3s=%0d want %s at edge %0d q=%0d r=%0d c6s=%0d c5s=%0d",
                     edge_n, bus.done, bus.err, q_out, r_out, n6, n5, n3, e.is_err ? "err" : "done", e.at, e.q, e.r,
                     e.is_err ? 0 : ITER, e.is_err ? 0 : $countones(e.q));
          end
        end
      end
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d outstanding results want 0", sb.size());
      end
    end
  end
  task automatic issue(input int hi, input int lo, input int dv);
    @(negedge clk);
    op_hi = hi;
    op_lo = lo;
    op_dv = dv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_end();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.err) break;
    end
  endtask
  task automatic run(input int hi, input int lo, input int dv);
    issue(hi, lo, dv);
    wait_end();
  endtask
  initial begin : stim
    int dv;
    int n;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    run(0, 100, 7);
    run(0, 55, 0);
    run(0, 255, 1);
    run(0, 0, 9);
    run(254, 255, 255);
    for (int k = 0; k < 24; k++) begin
      dv = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 255));
      run(dv > 0 ? int'($urandom_range(0, dv - 1)) : 0, int'($urandom_range(0, 255)), dv);
    end
    issue(0, 180, 11);
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.c4) n++;
    end
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_b = 1'b1;
    run(0, 100, 7);
    issue(0, 200, 13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.c6) break;
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_end();
    @(negedge clk);
    op_hi = 3;
    op_lo = 77;
    op_dv = 11;
    bus.start = 1'b1;
    repeat (80) @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    fin = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: ITER, default 8, number of shift/subtract iterations (quotient width).
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst_b  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: diff_neg  input  1  sign of datapath adder result (A - M); 1 = negative.
REQ-006 Port: m_zero  input  1  divisor register equals zero.
REQ-007 Port: c0  output  1  load register A from inbus (dividend high word).
REQ-008 Port: c1  output  1  load register Q from inbus (dividend low word).
REQ-009 Port: c2  output  1  load register M from inbus (divisor).
REQ-010 Port: c3  output  1  load register A from adder.
REQ-011 Port: c4  output  1  adder in subtract mode.
REQ-012 Port: c5  output  1  set Q[0] to 1.
REQ-013 Port: c6  output  1  shift A:Q left one bit.
REQ-014 Port: c7  output  1  drive Q (quotient) onto outbus.
REQ-015 Port: c8  output  1  drive A (remainder) onto outbus.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse, result fully output.
REQ-018 Port: err  output  1  one-cycle pulse, division by zero aborted.

Function
REQ-019 States SHALL be IDLE, LOAD_A, LOAD_Q, LOAD_M, CHECK, SHIFT, EVAL, OUT_Q, OUT_A, DONE, ERR.
REQ-020 IDLE -> LOAD_A when start=1; else stay; all c* low.
REQ-021 LOAD_A: c0=1; LOAD_Q: c1=1; LOAD_M: c2=1; each advances unconditionally.
REQ-022 CHECK: no c* asserted; m_zero=1 -> ERR, else -> SHIFT with iteration counter cleared to 0.
REQ-023 SHIFT: c6=1; -> EVAL.
REQ-024 EVAL: c4=1; if diff_neg=0 then c3=1 and c5=1 in same cycle (Mealy on diff_neg), else neither.
REQ-025 EVAL: counter=ITER-1 -> OUT_Q, else counter+1 and -> SHIFT; counter width ceil(log2(ITER)), never wraps past ITER-1.
REQ-026 OUT_Q: c7=1; OUT_A: c8=1; c7 and c8 never high together.
REQ-027 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-028 ERR: err=1 for exactly one cycle; -> IDLE; no SHIFT/EVAL performed.
REQ-029 Only one of c0,c1,c2,c3,c6,c7,c8 SHALL be high in any cycle (single register write/bus driver).
REQ-030 Latency: start sampled high at edge 0 -> done high in cycle 4+2*ITER+3 (23 for ITER=8).
REQ-031 start while busy=1 SHALL be ignored; start held high through DONE begins next division one cycle after DONE (from IDLE).
REQ-032 All outputs except c3/c5 SHALL be decoded from state register only.

Reset
REQ-033 rst_b=0 SHALL immediately force IDLE, counter=0, all outputs 0, regardless of current state.
REQ-034 Reset mid-operation SHALL abandon the division; no done or err pulse follows.

Structure
REQ-035 State encoding typedef and ITER default SHALL reside in the shared ALU package.
REQ-036 Iteration counter MAY be a sub-module div_iter_cnt (clear, inc, last flag); otherwise single module.

Verification
REQ-037 Dividend 100, divisor 7, ITER=8, behavioural A/Q/M/adder model -> Q=14, R=2, done at cycle 23, c6 pulsed 8 times, c5 pulsed 3 times.
REQ-038 Divisor 0 (m_zero=1 in CHECK) -> err pulse in cycle 5, c6/c3 never asserted, busy low next cycle.
REQ-039 rst_b low during 3rd EVAL -> all outputs 0 same cycle, IDLE, no done; fresh start then completes normally.
REQ-040 start pulsed during SHIFT -> ignored; exactly one done per accepted start.
REQ-041 start held high continuously -> back-to-back divisions, LOAD_A one cycle after each DONE.
REQ-042 Every cycle: assert one-hot rule of REQ-029 and busy == (state != IDLE).
